// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 serial byte receiver, LSB first, idle-high line.
//
// Turns the asynchronous UART pin into a parallel byte plus one-cycle strobes.
// rx_data is a level that holds the last correctly framed byte until the next
// good byte arrives. Each bit is sampled once, in the middle of the bit.
//
// Ports:
//   clk            in   system clock, all logic on posedge
//   rst            in   synchronous reset, active-high
//   rx_pin         in   asynchronous serial input, idle 1
//   rx_data        out  [7:0] last correctly framed byte
//   rx_data_valid  out  one-cycle strobe, rx_data updated this cycle
//   rx_frame_err   out  one-cycle strobe, stop bit sampled 0
module uart_byte_rx #(
  parameter int unsigned CLK_FRE   = 27,      // MHz
  parameter int unsigned BAUD_RATE = 115200   // bit/s
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       rx_frame_err
);

  localparam int unsigned CYCLE = CLK_FRE * 1_000_000 / BAUD_RATE;
  localparam int unsigned CntW  = $clog2(CYCLE + 1);

  localparam logic [CntW-1:0] CntMid  = CntW'(CYCLE / 2);
  localparam logic [CntW-1:0] CntLast = CntW'(CYCLE - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  // Synchroniser flops reset to 1 so a high line after reset is not an edge.
  logic rx_meta_q, rx_s_q, rx_s_d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_s_d_q  <= 1'b1;
    end else begin
      rx_meta_q <= rx_pin;
      rx_s_q    <= rx_meta_q;
      rx_s_d_q  <= rx_s_q;
    end
  end

  logic start_edge;
  logic at_mid;
  logic at_last;

  assign start_edge = rx_s_d_q & ~rx_s_q;
  assign at_mid     = (cyc_cnt_q == CntMid);
  assign at_last    = (cyc_cnt_q == CntLast);

  always_comb begin
    state_d   = state_q;
    cyc_cnt_d = at_last ? '0 : cyc_cnt_q + CntW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        cyc_cnt_d = '0;
        if (start_edge) begin
          state_d = StStart;
        end
      end

      StStart: begin
        if (at_mid && rx_s_q) begin
          // Start bit no longer low at its centre: treat as a line glitch.
          state_d   = StIdle;
          cyc_cnt_d = '0;
        end else if (at_last) begin
          state_d   = StData;
          cyc_cnt_d = '0;
          bit_idx_d = '0;
        end
      end

      StData: begin
        if (at_mid) begin
          shift_d[bit_idx_q] = rx_s_q;
        end
        if (at_last) begin
          cyc_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      StStop: begin
        // Leave at mid-stop so a start bit directly after the stop bit is caught.
        if (at_mid) begin
          state_d   = StIdle;
          cyc_cnt_d = '0;
          if (rx_s_q) begin
            rx_data_d = shift_q;
            valid_d   = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end

      default: begin
        state_d   = StIdle;
        cyc_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cyc_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= 8'h00;
      rx_data_q <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_cnt_q <= cyc_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_data_valid = valid_q;
  assign rx_frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx at the default 234 clocks per bit.
module tb_uart_byte_rx;

  localparam int BitClk = 234;

  logic       clk;
  logic       rst;
  logic       rx_pin;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_frame_err;

  uart_byte_rx dut (
    .clk           (clk),
    .rst           (rst),
    .rx_pin        (rx_pin),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_frame_err  (rx_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampled on the falling edge.
  int   ncyc = 0;
  int   nvalid = 0;
  int   nferr = 0;
  int   nviol = 0;
  int   last_valid_cyc = 0;
  logic prev_valid = 1'b0;
  logic prev_ferr = 1'b0;

  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (rx_data_valid === 1'b1) begin
      nvalid         <= nvalid + 1;
      last_valid_cyc <= ncyc;
    end
    if (rx_frame_err === 1'b1) nferr <= nferr + 1;
    if ((rx_data_valid === 1'b1 && rx_frame_err === 1'b1) ||
        (rx_data_valid === 1'b1 && prev_valid === 1'b1) ||
        (rx_frame_err === 1'b1 && prev_ferr === 1'b1)) begin
      nviol <= nviol + 1;
    end
    prev_valid <= rx_data_valid;
    prev_ferr  <= rx_frame_err;
  end

  int nvec = 0;
  int nerr = 0;
  int t_start = 0;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Call on a falling edge; returns on a falling edge after the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int bclk);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_pin = f[i];
      if (i == 0) t_start = ncyc;
      repeat (bclk) @(negedge clk);
    end
    rx_pin = 1'b1;
  endtask

  typedef struct {
    string      name;
    logic [7:0] data;
    logic       stop;
    int         bclk;
    int         gap;
    logic [7:0] exp_data;
    int         exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[10];
  int   v0, f0, lat;

  initial begin
    vecs[0] = '{"byte_39",      8'h39, 1'b1, BitClk, 300, 8'h39, 1, 0};
    vecs[1] = '{"b2b_30",       8'h30, 1'b1, BitClk, 0,   8'h30, 1, 0};
    vecs[2] = '{"b2b_35",       8'h35, 1'b1, BitClk, 300, 8'h35, 1, 0};
    vecs[3] = '{"byte_32",      8'h32, 1'b1, BitClk, 300, 8'h32, 1, 0};
    vecs[4] = '{"stop0_31",     8'h31, 1'b0, BitClk, 300, 8'h32, 0, 1};
    vecs[5] = '{"byte_ff",      8'hFF, 1'b1, BitClk, 300, 8'hFF, 1, 0};
    vecs[6] = '{"fast_55",      8'h55, 1'b1, 227,    0,   8'h55, 1, 0};
    vecs[7] = '{"fast_aa",      8'hAA, 1'b1, 227,    300, 8'hAA, 1, 0};
    vecs[8] = '{"slow_55",      8'h55, 1'b1, 241,    0,   8'h55, 1, 0};
    vecs[9] = '{"slow_aa",      8'hAA, 1'b1, 241,    300, 8'hAA, 1, 0};

    rst    = 1'b1;
    rx_pin = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("reset_data",  int'(rx_data), 8'h00);
    check("reset_valid", int'(rx_data_valid), 0);
    check("reset_ferr",  int'(rx_frame_err), 0);
    check("reset_pulses", nvalid + nferr, 0);

    foreach (vecs[i]) begin
      v0 = nvalid;
      f0 = nferr;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].bclk);
      check({vecs[i].name, "_valid"}, nvalid - v0, vecs[i].exp_valid);
      check({vecs[i].name, "_ferr"},  nferr - f0,  vecs[i].exp_ferr);
      check({vecs[i].name, "_data"},  int'(rx_data), int'(vecs[i].exp_data));
      if (vecs[i].bclk == BitClk && vecs[i].exp_valid == 1) begin
        lat = last_valid_cyc - t_start;
        check({vecs[i].name, "_latency_in_2220_2230"},
              int'(lat >= 2220 && lat <= 2230), 1);
      end
      repeat (vecs[i].gap) @(negedge clk);
    end

    // 50-clock low glitch while idle.
    v0 = nvalid;
    f0 = nferr;
    rx_pin = 1'b0;
    repeat (50) @(negedge clk);
    rx_pin = 1'b1;
    repeat (3000) @(negedge clk);
    check("glitch_valid", nvalid - v0, 0);
    check("glitch_ferr",  nferr - f0,  0);
    send_frame(8'h31, 1'b1, BitClk);
    check("after_glitch_valid", nvalid - v0, 1);
    check("after_glitch_data",  int'(rx_data), 8'h31);
    repeat (300) @(negedge clk);

    // Break: line held low for 20 bit times gives a single frame error.
    v0 = nvalid;
    f0 = nferr;
    rx_pin = 1'b0;
    repeat (20 * BitClk) @(negedge clk);
    rx_pin = 1'b1;
    repeat (500) @(negedge clk);
    check("break_ferr",  nferr - f0,  1);
    check("break_valid", nvalid - v0, 0);
    check("break_data",  int'(rx_data), 8'h31);

    // Reset during data bit 3 of 0x34 (bits 0..2 are 0,0,1).
    v0 = nvalid;
    f0 = nferr;
    rx_pin = 1'b0;
    repeat (BitClk) @(negedge clk);
    rx_pin = 1'b0;
    repeat (BitClk) @(negedge clk);
    rx_pin = 1'b0;
    repeat (BitClk) @(negedge clk);
    rx_pin = 1'b1;
    repeat (BitClk) @(negedge clk);
    rx_pin = 1'b0;
    repeat (BitClk / 2) @(negedge clk);
    rst    = 1'b1;
    rx_pin = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3000) @(negedge clk);
    check("midrst_pulses", (nvalid - v0) + (nferr - f0), 0);
    check("midrst_data",   int'(rx_data), 8'h00);
    send_frame(8'h33, 1'b1, BitClk);
    check("after_rst_valid", nvalid - v0, 1);
    check("after_rst_data",  int'(rx_data), 8'h33);
    repeat (300) @(negedge clk);

    check("strobe_overlap_or_width", nviol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
